// File: rtl/rk4_combine.sv
// rk4_combine: final RK4 combining stage.
// Steps the 4-to-1 k mux, accumulates k1+2k2+2k3+k4, scales by H/6 in
// fixed point and registers y(n+1) = y(n) + (H/6)*sum.
// Optional feature macro: RK4_SAT_EN (saturate y(n+1) instead of wrapping).
module rk4_combine #(
  parameter int unsigned N    = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] y_in,
  input  logic [N-1:0] h,
  output logic [1:0]   sel,
  input  logic [N-1:0] k_in,
  output logic [N-1:0] y_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned AW = N + 3;       // accumulator width
  localparam int unsigned PW = 2 * N + 3;   // acc*h product / t width
  localparam int unsigned QW = PW + 16;     // t*recip product width
  localparam int unsigned SW = QW + 1;      // yr + q sum width

  localparam logic signed [QW-1:0] RECIP = QW'(10923);
  localparam logic signed [SW-1:0] SMAX  = SW'((2 ** (N - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN  = ~SMAX;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    K0   = 3'd1,
    K1   = 3'd2,
    K2   = 3'd3,
    K3   = 3'd4,
    MUL  = 3'd5,
    DIV  = 3'd6
  } state_t;

  state_t                 state, state_nx;
  logic [1:0]             sel_nx;
  logic                   busy_nx;
  logic signed [N-1:0]    yr, hr;
  logic signed [AW-1:0]   acc;
  logic signed [PW-1:0]   t;

  logic signed [AW-1:0]   kw;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   t_nx;
  logic signed [QW-1:0]   qfull;
  logic signed [SW-1:0]   sum;
  logic [N-1:0]           fit_val;

  // Next-state, mux select and busy decode
  always_comb begin
    state_nx = state;
    sel_nx   = 2'd0;
    case (state)
      IDLE: if (start) state_nx = K0;
      K0:   state_nx = K1;
      K1:   state_nx = K2;
      K2:   state_nx = K3;
      K3:   state_nx = MUL;
      MUL:  state_nx = DIV;
      DIV:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    case (state_nx)
      K0:      sel_nx = 2'd0;
      K1:      sel_nx = 2'd1;
      K2:      sel_nx = 2'd2;
      K3:      sel_nx = 2'd3;
      default: sel_nx = 2'd0;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Fixed-point datapath: weighting, H scaling, divide-by-6, fit
  always_comb begin
    kw = AW'($signed(k_in));
    if (state == K1 || state == K2) begin
      kw = kw <<< 1;
    end
    prod    = PW'(acc) * PW'(hr);
    t_nx    = prod >>> FRAC;
    qfull   = (QW'(t) * RECIP) >>> 16;
    sum     = SW'(yr) + SW'(qfull);
    fit_val = sum[N-1:0];
`ifdef RK4_SAT_EN
    if (sum > SMAX) begin
      fit_val = SMAX[N-1:0];
    end else if (sum < SMIN) begin
      fit_val = SMIN[N-1:0];
    end
`endif
  end

`ifndef RK4_SAT_EN
  // Upper sum bits are dropped by the wrapping fit
  logic unused_sum;
  assign unused_sum = ^{sum[SW-1:N], SMIN[0]};
`endif

  // State, captured operands, accumulator and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      y_out <= '0;
      yr    <= '0;
      hr    <= '0;
      acc   <= '0;
      t     <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      busy  <= busy_nx;
      done  <= (state == DIV);
      case (state)
        IDLE: if (start) begin
          yr  <= $signed(y_in);
          hr  <= $signed(h);
          acc <= '0;
        end
        K0, K1, K2, K3: acc <= acc + kw;
        MUL: t <= t_nx;
        DIV: y_out <= fit_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rk4_combine.sv
// tb_rk4_combine: self-checking bench for rk4_combine with a cycle-level
// reference model and directed vectors.
module tb_rk4_combine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] y_in, h, k_in, y_out;
  logic [1:0]  sel;
  logic        busy, done;
  logic [15:0] kv [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;

  always #5 clk = ~clk;

  // Upstream combinational k mux
  assign k_in = kv[sel];

  rk4_combine #(.N(16), .FRAC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .y_in  (y_in),
    .h     (h),
    .sel   (sel),
    .k_in  (k_in),
    .y_out (y_out),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from plain integer arithmetic
  function automatic logic [15:0] model_y(input logic [15:0] y, input logic [15:0] hh,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
    longint s, tt, q, r;
    s  = longint'($signed(a)) + 2 * longint'($signed(b)) +
         2 * longint'($signed(c)) + longint'($signed(d));
    tt = (s * longint'($signed(hh))) >>> 8;
    q  = (tt * 64'sd10923) >>> 16;
    r  = longint'($signed(y)) + q;
`ifdef RK4_SAT_EN
    if (r > 64'sd32767)  r = 64'sd32767;
    if (r < -64'sd32768) r = -64'sd32768;
`endif
    return r[15:0];
  endfunction

  // Cycle model: m_cnt counts cycles since an accepted START (0 = idle)
  int          m_cnt;
  logic [15:0] m_res, m_y;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_y    = 16'h0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 6) begin
        m_y    = m_res;
        m_done = 1'b1;
        m_cnt  = 0;
      end else if (m_cnt != 0) begin
        m_cnt++;
      end else if (start) begin
        m_res = model_y(y_in, h, kv[0], kv[1], kv[2], kv[3]);
        m_cnt = 1;
      end
    end
  end

  always @(posedge clk) cyc++;

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("sel",  32'(sel),   (m_cnt >= 1 && m_cnt <= 4) ? 32'(m_cnt - 1) : 32'd0);
      check("busy", 32'(busy),  32'(m_cnt != 0));
      check("done", 32'(done),  32'(m_done));
      check("yout", 32'(y_out), 32'(m_y));
      if (done) begin
        done_cnt++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic load(input logic [15:0] y, input logic [15:0] hh,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
    y_in = y; h = hh; kv[0] = a; kv[1] = b; kv[2] = c; kv[3] = d;
  endtask

  task automatic run_vec(input string name, input logic [15:0] y, input logic [15:0] hh,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic [15:0] exp);
    int w;
    @(posedge clk); #1;
    load(y, hh, a, b, c, d);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    y_in  = ~y;
    h     = ~hh;
    w = 0;
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, "_done"},    32'(done),  32'd1);
    check({name, "_latency"}, 32'(w),     32'd7);
    check({name, "_yout"},    32'(y_out), 32'(exp));
    check({name, "_model"},   32'(model_y(y, hh, a, b, c, d)), 32'(exp));
  endtask

  initial begin
    int d0, w;
    rst_n = 1'b0;
    start = 1'b0;
    load(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel",  32'(sel),   32'd0);
    check("rst_busy", 32'(busy),  32'd0);
    check("rst_done", 32'(done),  32'd0);
    check("rst_yout", 32'(y_out), 32'd0);
    rst_n = 1'b1;

    run_vec("v1", 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run_vec("v2", 16'h0200, 16'h0080, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0340);
    run_vec("v3", 16'h0000, 16'h0100, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFEFF);
`ifdef RK4_SAT_EN
    run_vec("v4", 16'h7F00, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h7FFF);
`else
    run_vec("v4", 16'h7F00, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h8000);
`endif

    // Second START during K1 is ignored
    @(posedge clk); #1;
    load(16'h0200, 16'h0080, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("ignored_start_dones", 32'(done_cnt - d0), 32'd1);
    check("ignored_start_yout",  32'(y_out), 32'h0340);

    // Held START gives one result every 7 cycles
    d0 = done_cnt;
    start = 1'b1;
    w = 0;
    while (done_cnt - d0 < 3 && w < 40) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("stream_dones",    32'(done_cnt - d0), 32'd3);
    check("stream_interval", 32'(last_done_cyc - prev_done_cyc), 32'd7);
    start = 1'b0;
    repeat (10) @(posedge clk);

    // Reset during K2 aborts without DONE
    @(posedge clk); #1;
    load(16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("k2_sel_before_abort", 32'(sel), 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_sel",  32'(sel),   32'd0);
    check("abort_busy", 32'(busy),  32'd0);
    check("abort_yout", 32'(y_out), 32'd0);
    check("abort_done", 32'(done),  32'd0);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_yout_held", 32'(y_out), 32'd0);
    run_vec("v1_after_rst", 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
